// File: rtl/sram_burst_master.sv
// -----------------------------------------------------------------------------
// sram_burst_master
//
// Burst initiator for the on-chip config SRAM. Takes one command (read or
// write, base byte address, word count, byte mask) from the control plane and
// then moves the words over valid/ready streams. Every SRAM access cycle is
// generated here.
//
// Ports:
//   clk, rst_n                  clock (posedge) and async active-low reset
//   cmd_valid/cmd_ready         command handshake
//   cmd_write/addr/len/sel      command fields (len 0..256 legal)
//   wr_valid/wr_ready/wr_data   write-data stream into the SRAM
//   rd_valid/rd_ready/rd_data   read-data stream out of the SRAM
//   busy, done, err             status; done/err are one-cycle pulses
//   ce_o, we_o, addr_o, sel_o,  SRAM access port (driven combinationally)
//   data_o, data_i              data_i is combinational read data
// -----------------------------------------------------------------------------
module sram_burst_master #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 8,
    parameter int LEN_W      = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [3:0]        cmd_sel,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              ce_o,
    output logic              we_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [3:0]        sel_o,
    output logic [DATA_W-1:0] data_o,
    input  logic [DATA_W-1:0] data_i
);

    // Word index occupies addr[IDX_HI:2]; it wraps inside the SRAM while the
    // bits above it keep the base value.
    localparam int               IDX_HI  = DEPTH_LOG2 + 1;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1 << DEPTH_LOG2);
    localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_FIN
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
    logic [LEN_W-1:0]    remaining_q, remaining_d;
    logic [3:0]          sel_q, sel_d;
    logic                err_q, err_d;
    logic                rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                issue;

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] r;
        r            = a;
        r[IDX_HI:2]  = a[IDX_HI:2] + 1'b1;
        return r;
    endfunction

    // NOTE: every signal written here gets a default first so no path can
    // leave it unassigned; that is what keeps this block free of latches.
    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        sel_d       = sel_q;
        err_d       = err_q;
        rd_valid_d  = rd_valid_q;
        rd_data_d   = rd_data_q;
        issue       = 1'b0;
        wr_ready    = 1'b0;
        ce_o        = 1'b0;
        we_o        = 1'b0;
        addr_o      = '0;
        sel_o       = '0;
        data_o      = '0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    cur_addr_d  = {cmd_addr[ADDR_W-1:2], 2'b00};
                    remaining_d = cmd_len;
                    sel_d       = cmd_sel;
                    err_d       = 1'b0;
                    if (cmd_len == '0) begin
                        state_d = S_FIN;
                    end else if (cmd_len > MAX_LEN) begin
                        err_d   = 1'b1;
                        state_d = S_FIN;
                    end else begin
                        state_d = cmd_write ? S_WRITE : S_READ;
                    end
                end
            end

            S_WRITE: begin
                wr_ready = 1'b1;
                addr_o   = cur_addr_q;
                if (wr_valid) begin
                    ce_o        = 1'b1;
                    we_o        = 1'b1;
                    sel_o       = sel_q;
                    data_o      = wr_data;
                    cur_addr_d  = next_addr(cur_addr_q);
                    remaining_d = remaining_q - ONE;
                    if (remaining_q == ONE) state_d = S_FIN;
                end
            end

            S_READ: begin
                // Only fetch when the single output slot is empty or being
                // emptied this cycle, so a stalled word is never overwritten.
                issue  = (!rd_valid_q || rd_ready) && (remaining_q != '0);
                addr_o = cur_addr_q;
                if (issue) begin
                    ce_o        = 1'b1;
                    sel_o       = 4'hF;
                    rd_data_d   = data_i;
                    rd_valid_d  = 1'b1;
                    cur_addr_d  = next_addr(cur_addr_q);
                    remaining_d = remaining_q - ONE;
                    if (remaining_q == ONE) state_d = S_DRAIN;
                end else if (rd_ready) begin
                    rd_valid_d = 1'b0;
                end
            end

            S_DRAIN: begin
                if (rd_valid_q && rd_ready) begin
                    rd_valid_d = 1'b0;
                    state_d    = S_FIN;
                end
            end

            S_FIN: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            sel_q       <= '0;
            err_q       <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            sel_q       <= sel_d;
            err_q       <= err_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_FIN);
    assign err       = (state_q == S_FIN) && err_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_sram_burst_master.sv
// -----------------------------------------------------------------------------
// tb_sram_burst_master
//
// Self-checking bench for sram_burst_master. A behavioural SRAM sits on the
// access port; a separate reference memory predicts contents. Expected SRAM
// accesses and read words are queued when a command is driven and popped by a
// monitor when the DUT produces them.
// -----------------------------------------------------------------------------
module tb_sram_burst_master;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 9;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid, cmd_ready, cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic [3:0]        cmd_sel;
    logic              wr_valid, wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid, rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              busy, done, err;
    logic              ce_o, we_o;
    logic [ADDR_W-1:0] addr_o;
    logic [3:0]        sel_o;
    logic [DATA_W-1:0] data_o, data_i;

    always #5 clk = ~clk;

    sram_burst_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH_LOG2(8), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_sel(cmd_sel),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .busy(busy), .done(done), .err(err),
        .ce_o(ce_o), .we_o(we_o), .addr_o(addr_o), .sel_o(sel_o),
        .data_o(data_o), .data_i(data_i)
    );

    // Behavioural SRAM: combinational read, byte-lane write on posedge.
    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];

    assign data_i = mem[addr_o[9:2]];

    always @(posedge clk) begin
        if (ce_o && we_o) begin
            for (int b = 0; b < 4; b++)
                if (sel_o[b]) mem[addr_o[9:2]][8*b +: 8] <= data_o[8*b +: 8];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard queues.
    logic [31:0] exp_wa[$];
    logic [31:0] exp_wd[$];
    logic [3:0]  exp_ws[$];
    logic [31:0] exp_ra[$];
    logic [31:0] exp_rd[$];

    int ce_cnt   = 0;
    int done_cnt = 0;

    // Monitor: samples 1 ns after the falling edge, well away from posedge.
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = '0;

    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (ce_o && we_o) begin
                ce_cnt++;
                if (exp_wa.size() == 0) check("wr_unexpected", 1, 0);
                else begin
                    check("wr_addr", addr_o, exp_wa.pop_front());
                    check("wr_data", data_o, exp_wd.pop_front());
                    check("wr_sel", {28'd0, sel_o}, {28'd0, exp_ws.pop_front()});
                end
            end else if (ce_o) begin
                ce_cnt++;
                check("rd_sel", {28'd0, sel_o}, 32'hF);
                check("rd_slot_free", {31'd0, (!rd_valid || rd_ready)}, 1);
                if (exp_ra.size() == 0) check("rd_unexpected", 1, 0);
                else check("rd_addr", addr_o, exp_ra.pop_front());
            end else begin
                check("idle_we", {31'd0, we_o}, 0);
                check("idle_data", data_o, 0);
                check("idle_sel", {28'd0, sel_o}, 0);
            end
            if (prev_stall && rd_valid) check("rd_hold", rd_data, prev_data);
            if (rd_valid && rd_ready) begin
                if (exp_rd.size() == 0) check("rd_word_unexpected", 1, 0);
                else check("rd_word", rd_data, exp_rd.pop_front());
            end
            prev_stall = rd_valid && !rd_ready;
            prev_data  = rd_data;
            if (done) done_cnt++;
        end
    end

    // One complete burst: predicts accesses, drives the command and data,
    // waits (bounded) for done, then checks the burst-level results.
    task automatic run_burst(input bit wr, input logic [31:0] addr, input int len,
                             input logic [3:0] sel, input logic [31:0] dbase,
                             input bit gaps, input bit stall, input int exp_cyc);
        int          n_words;
        bit          exp_err;
        logic [7:0]  idx;
        logic [31:0] a, d;
        int          ce0, d0, cyc, w, cyc_done;
        bit          finished, got_err;
        logic [4:0]  pat;
        pat      = 5'b11001;  // rd_ready per cycle: 1,0,0,1,1
        n_words  = (len >= 1 && len <= 256) ? len : 0;
        exp_err  = (len > 256);
        for (int i = 0; i < n_words; i++) begin
            idx = addr[9:2] + 8'(i);
            a   = {addr[31:10], idx, 2'b00};
            if (wr) begin
                d = dbase + 32'(i);
                exp_wa.push_back(a);
                exp_wd.push_back(d);
                exp_ws.push_back(sel);
                for (int b = 0; b < 4; b++)
                    if (sel[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
            end else begin
                exp_ra.push_back(a);
                exp_rd.push_back(ref_mem[idx]);
            end
        end
        ce0 = ce_cnt;
        d0  = done_cnt;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_len   = LEN_W'(len);
        cmd_sel   = sel;
        #1;
        check("cmd_ready", {31'd0, cmd_ready}, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        cyc = 0; w = 0; finished = 0; got_err = 0; cyc_done = -1;
        while (!finished && cyc < 2000) begin
            if (wr && w < n_words && !(gaps && (cyc % 3 == 1))) begin
                wr_valid = 1'b1;
                wr_data  = dbase + 32'(w);
            end else begin
                wr_valid = 1'b0;
            end
            rd_ready = stall ? pat[cyc % 5] : 1'b1;
            #1;
            if (done) begin
                finished = 1;
                got_err  = err;
                cyc_done = cyc;
            end
            if (wr_valid && wr_ready) w++;
            @(negedge clk);
            cyc++;
        end
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        check("done_seen", {31'd0, finished}, 1);
        check("err_flag", {31'd0, got_err}, {31'd0, exp_err});
        if (exp_cyc >= 0) check("burst_cycles", cyc_done, exp_cyc);
        #2;
        check("done_single", {31'd0, done}, 0);
        check("busy_after", {31'd0, busy}, 0);
        check("access_count", ce_cnt - ce0, n_words);
        check("done_count", done_cnt - d0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        int ce0, d0;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 32'hA500_0000 | 32'(i);
            ref_mem[i] = 32'hA500_0000 | 32'(i);
        end
        cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0; cmd_sel = '0;
        wr_valid = 0; wr_data = '0; rd_ready = 0;

        // Reset state.
        @(negedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_ce", {31'd0, ce_o}, 0);
        check("rst_rd_valid", {31'd0, rd_valid}, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_done", {30'd0, done, err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_cmd_ready", {31'd0, cmd_ready}, 1);

        // Write then read back, full throughput.
        run_burst(1, 32'h10, 4, 4'hF, 32'hA0, 0, 0, 4);
        run_burst(0, 32'h10, 4, 4'hF, 32'h0, 0, 0, 5);

        // Byte mask: expect 0xFF34FF78 on readback.
        run_burst(1, 32'h20, 1, 4'hF, 32'hFFFF_FFFF, 0, 0, 1);
        run_burst(1, 32'h20, 1, 4'b0101, 32'h1234_5678, 0, 0, 1);
        check("mask_model", ref_mem[8], 32'hFF34_FF78);
        run_burst(0, 32'h20, 1, 4'hF, 32'h0, 0, 0, 2);

        // Backpressure on reads.
        run_burst(0, 32'h10, 3, 4'hF, 32'h0, 0, 1, -1);

        // Index wrap with upper address bits held; write with data gaps.
        run_burst(1, 32'h13F8, 3, 4'hF, 32'hB0, 1, 0, -1);
        run_burst(0, 32'h3F8, 3, 4'hF, 32'h0, 0, 0, 4);

        // Misaligned base forces low bits to zero.
        run_burst(1, 32'h013, 1, 4'hF, 32'h5555_0013, 0, 0, 1);
        run_burst(0, 32'h010, 1, 4'hF, 32'h0, 0, 0, 2);

        // Edge lengths.
        run_burst(1, 32'h40, 0, 4'hF, 32'h0, 0, 0, 0);
        run_burst(0, 32'h40, 300, 4'hF, 32'h0, 0, 0, 0);
        run_burst(1, 32'h40, 300, 4'hF, 32'h0, 0, 0, 0);
        run_burst(1, 32'h100, 256, 4'hF, 32'h1000, 0, 0, 256);
        run_burst(0, 32'h000, 256, 4'hF, 32'h0, 0, 0, 257);

        // Reset mid-burst after 2 of 5 words.
        for (int i = 0; i < 2; i++) begin
            exp_wa.push_back(32'h40 + 32'(4 * i));
            exp_wd.push_back(32'hC0 + 32'(i));
            exp_ws.push_back(4'hF);
            ref_mem[16 + i] = 32'hC0 + 32'(i);
        end
        ce0 = ce_cnt;
        d0  = done_cnt;
        @(negedge clk);
        cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h40; cmd_len = 9'd5; cmd_sel = 4'hF;
        @(negedge clk);
        cmd_valid = 0;
        wr_valid = 1; wr_data = 32'hC0;
        @(negedge clk);
        wr_data = 32'hC1;
        @(negedge clk);
        wr_data = 32'hC2;
        rst_n = 1'b0;
        #2;
        check("mid_rst_ce", {31'd0, ce_o}, 0);
        check("mid_rst_we", {31'd0, we_o}, 0);
        check("mid_rst_addr", addr_o, 0);
        check("mid_rst_data", data_o, 0);
        check("mid_rst_sel", {28'd0, sel_o}, 0);
        check("mid_rst_status", {29'd0, busy, done, err}, 0);
        check("mid_rst_wr_ready", {31'd0, wr_ready}, 0);
        wr_valid = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        check("post_rst_cmd_ready", {31'd0, cmd_ready}, 1);
        check("post_rst_done_count", done_cnt - d0, 0);
        check("post_rst_access_count", ce_cnt - ce0, 2);
        run_burst(0, 32'h40, 3, 4'hF, 32'h0, 0, 0, 4);

        check("wr_queue_empty", exp_wa.size(), 0);
        check("rd_addr_queue_empty", exp_ra.size(), 0);
        check("rd_word_queue_empty", exp_rd.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_burst_master.md
Name: sram_burst_master

Overview:
- Initiator for the on-chip config SRAM's ce/we/addr/sel/data port.
- Accepts one burst command (read or write, base byte address, word count, byte mask) from the control plane, then streams words in or out over valid/ready.
- Generates every SRAM access cycle by cycle.
- Sits between the table-load/readback logic and the SRAM instance.

Parameters:
- ADDR_W, 32, byte-address width; matches ADDR_BUS.
- DATA_W, 32, word width; matches DATA_BUS; four byte lanes.
- DEPTH_LOG2, 8, SRAM word-index width (256 words, index = addr[9:2]).
- LEN_W, 9, burst length field width.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when both high.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  ADDR_W  base byte address.
- cmd_len  in  LEN_W  word count, 0..256 legal.
- cmd_sel  in  4  byte-lane mask applied to every write word.
- wr_valid  in  1  write-data word offered.
- wr_ready  out  1  write word consumed when both high.
- wr_data  in  DATA_W  write data.
- rd_valid  out  1  read word available.
- rd_ready  in  1  consumer accepts read word.
- rd_data  out  DATA_W  read data.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse at burst end.
- err  out  1  one-cycle pulse with done for a rejected command.
- ce_o  out  1  SRAM chip enable.
- we_o  out  1  SRAM write enable.
- addr_o  out  ADDR_W  SRAM byte address.
- sel_o  out  4  SRAM byte select.
- data_o  out  DATA_W  SRAM write data.
- data_i  in  DATA_W  SRAM read data; combinational, valid the same cycle ce_o=1 and we_o=0.

Behaviour:
- Reset (async, rst_n=0): state IDLE, counters cleared.
  - Outputs: rd_valid=0, rd_data=0, busy=0, done=0, err=0, ce_o=0, we_o=0, addr_o=0, sel_o=0, data_o=0.
  - cmd_ready=1 once in IDLE. SRAM contents untouched.
  - Reset mid-burst aborts immediately; no done pulse.
- FSM states: IDLE, WRITE, READ, DRAIN, FIN.
  - cmd_ready = (state==IDLE); busy = (state!=IDLE).
- IDLE, on accept:
  - Latch cur_addr = {cmd_addr[ADDR_W-1:2], 2'b00} (low bits forced to 0); remaining = cmd_len; sel = cmd_sel.
  - cmd_len==0 -> FIN; cmd_len>256 -> FIN with err; else cmd_write ? WRITE : READ.
- WRITE:
  - wr_ready=1.
  - ce_o=we_o=wr_valid; addr_o=cur_addr; sel_o=latched sel; data_o=wr_data (all combinational).
  - Each handshake: cur_addr advances one word; remaining decrements; remaining reaching 0 -> FIN.
  - wr_valid=0 holds ce_o=0; no access.
- READ:
  - issue = (!rd_valid || rd_ready) && remaining!=0.
  - ce_o=issue, we_o=0, sel_o=4'hF, addr_o=cur_addr.
  - On issue: rd_data<=data_i, rd_valid<=1, advance address, decrement remaining.
  - rd_ready && !issue clears rd_valid.
  - Throughput 1 word/cycle with rd_ready held high; latency from issue to rd_valid is 1 cycle.
  - Last issue -> DRAIN.
- DRAIN: no SRAM access; wait until rd_valid && rd_ready, then -> FIN.
- FIN: done=1 (err=1 if rejected) for exactly one cycle, then -> IDLE.
- Address increment: word index addr[9:2] increments modulo 256 (0x3FC -> 0x000); bits above 9 hold the base value.
- data_o=0 and sel_o=0 whenever ce_o=0.
- No new command is accepted while busy; cmd_valid is ignored.

Test Plan:
- Write then read back:
  - Write cmd addr=0x10, len=4, sel=F, data A0..A3 -> four we_o pulses at 0x10,0x14,0x18,0x1C; done one cycle after the last.
  - Read cmd same range -> rd_data A0,A1,A2,A3 on consecutive cycles with rd_ready=1.
- Byte mask:
  - Write 0xFFFFFFFF to 0x20 with sel=F, then 0x12345678 with sel=4'b0101 -> readback 0xFF34FF78.
- Backpressure:
  - Read len=3 with rd_ready toggling 1,0,0,1,1 -> ce_o only when the output slot is free.
  - rd_data held stable while stalled; exactly 3 words delivered in order.
- Wrap:
  - Write len=3 at 0x3F8 -> accesses at 0x3F8, 0x3FC, 0x000.
  - Misaligned base 0x013 -> first access at 0x010.
- Edge lengths:
  - len=0 -> done pulse, err=0, no ce_o.
  - len=300 -> done and err pulse together, no ce_o.
  - len=256 -> 256 accesses.
- Reset mid-burst:
  - rst_n low during a write after 2 of 5 words -> all outputs 0 immediately, no done pulse.
  - After release, cmd_ready=1; those 2 words are retained in SRAM.
